// File: rtl/rdecode_wb_if.sv
// Pipeline-side signal bundle for the Y86-64 decode/write-back stage.
interface rdecode_wb_if;
    // D pipeline register
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    // Forwarding sources
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    // Decode results towards the E register
    logic [3:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    // Debug read port
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
               e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM, dbg_addr,
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, dbg_data
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
               e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM, dbg_addr,
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, dbg_data
    );
endinterface

// File: rtl/rdecode_wb.sv
// Y86-64 decode/write-back stage: register file, operand decode and forwarding.
module rdecode_wb #(
    parameter logic [63:0] RSP_INIT = 64'd0,
    parameter logic [3:0]  RNONE    = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    rdecode_wb_if.slave  io
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RSP = 4'd4;

    logic [63:0] regs_q [15];
    logic [63:0] regs_d [15];
    logic [3:0]  src_a;
    logic [3:0]  src_b;

    // Forwarding chain shared by both operands; youngest producer wins.
    function automatic logic [63:0] fwd_sel(input logic [3:0] src);
        logic [63:0] v;
        v = '0;
        if (src == RNONE)             v = '0;
        else if (src == io.e_dstE)    v = io.e_valE;
        else if (src == io.M_dstM)    v = io.m_valM;
        else if (src == io.M_dstE)    v = io.M_valE;
        else if (src == io.W_dstM)    v = io.W_valM;
        else if (src == io.W_dstE)    v = io.W_valE;
        else                          v = regs_q[src];
        return v;
    endfunction

    // Decode register IDs from the instruction code.
    always_comb begin
        src_a     = RNONE;
        src_b     = RNONE;
        io.d_dstE = RNONE;
        io.d_dstM = RNONE;
        case (io.D_icode)
            I_RRMOVQ: begin src_a = io.D_rA; io.d_dstE = io.D_rB; end
            I_IRMOVQ: io.d_dstE = io.D_rB;
            I_RMMOVQ: begin src_a = io.D_rA; src_b = io.D_rB; end
            I_MRMOVQ: begin src_b = io.D_rB; io.d_dstM = io.D_rA; end
            I_OPQ:    begin src_a = io.D_rA; src_b = io.D_rB; io.d_dstE = io.D_rB; end
            I_CALL:   begin src_b = RSP; io.d_dstE = RSP; end
            I_RET:    begin src_a = RSP; src_b = RSP; io.d_dstE = RSP; end
            I_PUSHQ:  begin src_a = io.D_rA; src_b = RSP; io.d_dstE = RSP; end
            I_POPQ:   begin src_a = RSP; src_b = RSP; io.d_dstE = RSP; io.d_dstM = io.D_rA; end
            default:  ;
        endcase
    end

    // Operand selection and pass-through outputs.
    always_comb begin
        io.d_srcA  = src_a;
        io.d_srcB  = src_b;
        io.d_stat  = io.D_stat;
        io.d_icode = io.D_icode;
        io.d_ifun  = io.D_ifun;
        io.d_valC  = io.D_valC;
        if (io.D_icode == I_CALL || io.D_icode == I_JXX)
            io.d_valA = io.D_valP;
        else
            io.d_valA = fwd_sel(src_a);
        io.d_valB = fwd_sel(src_b);
    end

    // Debug read of the raw register file.
    always_comb begin
        io.dbg_data = '0;
        if (io.dbg_addr != RNONE)
            io.dbg_data = regs_q[io.dbg_addr];
    end

    // Next register file contents; the M write is applied last so it wins a tie.
    always_comb begin
        for (int unsigned i = 0; i < 15; i++)
            regs_d[i] = regs_q[i];
        if (io.W_dstE != RNONE)
            regs_d[io.W_dstE] = io.W_valE;
        if (io.W_dstM != RNONE)
            regs_d[io.W_dstM] = io.W_valM;
    end

    // Register file update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++)
                regs_q[i] <= (i == 4) ? RSP_INIT : '0;
        end else begin
            for (int unsigned i = 0; i < 15; i++)
                regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_rdecode_wb.sv
module tb_rdecode_wb;

    localparam logic [63:0] RSP_INIT = 64'h200;
    localparam logic [3:0]  NONE     = 4'hF;

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
        logic [63:0] dbg;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic [63:0] ref_rf [16];

    rdecode_wb_if bus ();

    rdecode_wb #(.RSP_INIT(RSP_INIT), .RNONE(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_srcA(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_srcB(logic [3:0] ic, logic [3:0] rb);
        if (ic inside {4'h6, 4'h4, 4'h5}) return rb;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'd4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_dstE(logic [3:0] ic, logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'd4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_dstM(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return NONE;
    endfunction

    function automatic logic [63:0] m_operand(logic [3:0] src);
        logic [3:0]  dsts [5];
        logic [63:0] vals [5];
        if (src == NONE) return '0;
        dsts = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        for (int k = 0; k < 5; k++)
            if (dsts[k] == src) return vals[k];
        return ref_rf[src];
    endfunction

    // Register file as seen after the edge that just happened.
    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < 16; r++) ref_rf[r] = '0;
            ref_rf[4] = RSP_INIT;
        end else begin
            if (bus.W_dstE != NONE) ref_rf[bus.W_dstE] = bus.W_valE;
            if (bus.W_dstM != NONE) ref_rf[bus.W_dstM] = bus.W_valM;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.stat  = bus.D_stat;
        e.icode = bus.D_icode;
        e.ifun  = bus.D_ifun;
        e.valC  = bus.D_valC;
        e.srcA  = m_srcA(bus.D_icode, bus.D_rA);
        e.srcB  = m_srcB(bus.D_icode, bus.D_rB);
        e.dstE  = m_dstE(bus.D_icode, bus.D_rB);
        e.dstM  = m_dstM(bus.D_icode, bus.D_rA);
        e.valA  = (bus.D_icode inside {4'h7, 4'h8}) ? bus.D_valP : m_operand(e.srcA);
        e.valB  = m_operand(e.srcB);
        e.dbg   = (bus.dbg_addr == NONE) ? 64'd0 : ref_rf[bus.dbg_addr];
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_fwd();
        bus.e_dstE = NONE; bus.M_dstE = NONE; bus.M_dstM = NONE;
        bus.W_dstE = NONE; bus.W_dstM = NONE;
    endtask

    task automatic set_instr(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb);
        bus.D_icode = ic; bus.D_rA = ra; bus.D_rB = rb;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("d_stat",   64'(bus.d_stat),  64'(e.stat));
            chk("d_icode",  64'(bus.d_icode), 64'(e.icode));
            chk("d_ifun",   64'(bus.d_ifun),  64'(e.ifun));
            chk("d_valC",   bus.d_valC,       e.valC);
            chk("d_valA",   bus.d_valA,       e.valA);
            chk("d_valB",   bus.d_valB,       e.valB);
            chk("d_dstE",   64'(bus.d_dstE),  64'(e.dstE));
            chk("d_dstM",   64'(bus.d_dstM),  64'(e.dstM));
            chk("d_srcA",   64'(bus.d_srcA),  64'(e.srcA));
            chk("d_srcB",   64'(bus.d_srcB),  64'(e.srcB));
            chk("dbg_data", bus.dbg_data,     e.dbg);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int r = 0; r < 16; r++) ref_rf[r] = '0;
        rst = 1'b1;
        bus.D_stat = 4'h1; bus.D_ifun = 4'h0;
        bus.D_valC = 64'h0; bus.D_valP = 64'h0;
        set_instr(4'h1, NONE, NONE);
        clear_fwd();
        bus.e_valE = '0; bus.M_valE = '0; bus.m_valM = '0;
        bus.W_valE = '0; bus.W_valM = '0;
        bus.dbg_addr = 4'd4;
        // write during reset must be dropped
        bus.W_dstE = 4'd3; bus.W_valE = 64'd5;
        tick();

        rst = 1'b0; clear_fwd(); bus.dbg_addr = 4'd4; push_expect();
        tick(); bus.dbg_addr = 4'd3; push_expect();

        // simple write then read with no forwarding
        tick(); bus.W_dstE = 4'd2; bus.W_valE = 64'h11; push_expect();
        tick(); clear_fwd(); set_instr(4'h6, 4'd2, 4'd2); bus.dbg_addr = 4'd2; push_expect();

        // forwarding priority e > M > W
        tick(); set_instr(4'h6, 4'd1, 4'd0);
        bus.e_dstE = 4'd1; bus.e_valE = 64'd7;
        bus.M_dstE = 4'd1; bus.M_valE = 64'd8;
        bus.W_dstE = 4'd1; bus.W_valE = 64'd9; push_expect();
        tick(); bus.e_dstE = NONE; push_expect();
        tick(); bus.M_dstE = NONE; push_expect();

        // CALL takes valP for A, forwarded rsp for B
        tick(); clear_fwd(); set_instr(4'h8, NONE, NONE);
        bus.D_valP = 64'h40; bus.e_dstE = 4'd4; bus.e_valE = 64'h1F0; push_expect();

        // simultaneous E and M write to the same register
        tick(); clear_fwd(); set_instr(4'h1, NONE, NONE);
        bus.W_dstE = 4'd4; bus.W_valE = 64'h100;
        bus.W_dstM = 4'd4; bus.W_valM = 64'h1F8; push_expect();
        tick(); clear_fwd(); bus.dbg_addr = 4'd4; push_expect();

        // RNONE destination is never written
        tick(); set_instr(4'h3, NONE, NONE); bus.W_dstE = NONE; bus.W_valE = 64'hDEAD;
        bus.dbg_addr = NONE; push_expect();
        tick(); clear_fwd(); bus.dbg_addr = 4'd14; push_expect();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            tick();
            rst          = ($urandom_range(0, 39) == 0);
            bus.D_stat   = 4'($urandom);
            bus.D_icode  = 4'($urandom);
            bus.D_ifun   = 4'($urandom);
            bus.D_rA     = 4'($urandom);
            bus.D_rB     = 4'($urandom);
            bus.D_valC   = {$urandom, $urandom};
            bus.D_valP   = {$urandom, $urandom};
            bus.e_dstE   = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom);
            bus.M_dstE   = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom);
            bus.M_dstM   = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom);
            bus.W_dstE   = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom);
            bus.W_dstM   = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom);
            bus.e_valE   = {$urandom, $urandom};
            bus.M_valE   = {$urandom, $urandom};
            bus.m_valM   = {$urandom, $urandom};
            bus.W_valE   = {$urandom, $urandom};
            bus.W_valM   = {$urandom, $urandom};
            bus.dbg_addr = 4'($urandom);
            push_expect();
        end

        // drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdecode_wb.md
Name: rdecode_wb

Overview:
- Decode/write-back stage of the 5-stage Y86-64 pipeline.
- Sits between the D pipeline register and the E pipeline register. It produces every d_* value the E register latches.
- Holds the 15-entry x 64-bit architectural register file, which is written from the W stage.
- Selects operand sources with full forwarding from the E, M and W stages.

Parameters:
- RSP_INIT, 64'd0, value loaded into %rsp (reg 4) on reset; all other registers reset to 0.
- RNONE, 4'hF, register ID meaning "no register"; never read from or written to the file.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- D_stat  in  4  status from D register
- D_icode, D_ifun  in  4 each  instruction code/function from D register
- D_rA, D_rB  in  4 each  register specifiers
- D_valC, D_valP  in  64 each  constant, next-PC
- e_dstE  in  4  execute-stage destination (already condition-gated for cmov)
- e_valE  in  64  execute-stage ALU result
- M_dstE, M_dstM  in  4 each  memory-stage destinations
- M_valE  in  64  memory-stage ALU result
- m_valM  in  64  memory read data
- W_dstE, W_dstM  in  4 each  write-back destinations
- W_valE, W_valM  in  64 each  write-back data
- d_stat, d_icode, d_ifun  out  4 each  pass-through of D_stat/D_icode/D_ifun
- d_valC  out  64  pass-through of D_valC
- d_valA, d_valB  out  64 each  selected operands
- d_dstE, d_dstM, d_srcA, d_srcB  out  4 each  decoded register IDs
- dbg_addr  in  4  debug read index
- dbg_data  out  64  register file contents at dbg_addr, un-forwarded; 0 for RNONE

Behaviour:
- icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RSP = 4.
- srcA:
  - D_rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ
  - RSP for POPQ, RET
  - else RNONE
- srcB:
  - D_rB for OPQ, RMMOVQ, MRMOVQ
  - RSP for PUSHQ, POPQ, CALL, RET
  - else RNONE
- dstE:
  - D_rB for RRMOVQ, IRMOVQ, OPQ
  - RSP for PUSHQ, POPQ, CALL, RET
  - else RNONE
- dstM: D_rA for MRMOVQ, POPQ; else RNONE.
- Unrecognised icode: all four IDs are RNONE, d_valA = d_valB = 0.
- d_valA priority, first match wins:
  1. D_valP if icode is CALL or JXX
  2. e_valE if srcA==e_dstE
  3. m_valM if srcA==M_dstM
  4. M_valE if srcA==M_dstE
  5. W_valM if srcA==W_dstM
  6. W_valE if srcA==W_dstE
  7. otherwise register file
- d_valB: same chain with srcB, without the D_valP term.
- A match is only valid when the source is not RNONE. An RNONE source yields 0.
- All decode/select outputs are combinational, zero latency from D_* and forwarding inputs.
- Register file:
  - Posedge write of W_valE to W_dstE and W_valM to W_dstM; RNONE writes are ignored.
  - If W_dstE==W_dstM (not RNONE), W_valM wins.
  - Reads are asynchronous. A same-cycle write/read is covered by W forwarding, so no internal bypass is needed.
- Reset: on posedge with rst=1, regs 0-14 = 0 except reg 4 = RSP_INIT. W writes in that cycle are discarded.
  - Outputs remain combinational during reset.
  - Reset asserted mid-program takes effect at that edge; forwarding inputs are still honoured.

Test Plan:
- Reset with RSP_INIT=64'h200 -> dbg_data(4)=64'h200, dbg_data(3)=0. A W_dstE=3/W_valE=5 write in the reset cycle is dropped.
- W_dstE=2, W_valE=64'h11 for one cycle, then OPQ rA=2 rB=2 with no forwarding -> d_valA=d_valB=64'h11, d_dstE=2, d_srcA=2.
- OPQ rA=1 with e_dstE=1/e_valE=7, M_dstE=1/M_valE=8, W_dstE=1/W_valE=9 -> d_valA=7. Removing e_dstE -> 8. Also removing M_dstE -> 9.
- CALL with D_valP=64'h40 and e_dstE=4 -> d_valA=64'h40, d_valB=e_valE, d_dstE=4, d_srcA=RNONE.
- W_dstE=4/W_valE=64'h100 and W_dstM=4/W_valM=64'h1F8 in the same cycle -> dbg_data(4)=64'h1F8 afterwards.
- IRMOVQ rB=RNONE (15) with W_dstE=15 -> no register changes, d_valA=d_valB=0, d_dstE=RNONE.
